// File: rtl/filter_stats_pkg.sv
// ============================================================================
//  Module  : filter_stats_pkg
//  Purpose : Shared constants and types for the port statistics CSR block:
//            register addresses, counter-type encoding and ctrl bit positions.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package filter_stats_pkg;

    // Word addresses of the scalar registers
    localparam logic [7:0] REG_PORT_MASK   = 8'h00;
    localparam logic [7:0] REG_CTRL        = 8'h01;
    localparam logic [7:0] REG_IRQ_STATUS  = 8'h02;
    localparam logic [7:0] REG_IRQ_ENABLE  = 8'h03;
    localparam logic [7:0] REG_DROP_THRESH = 8'h04;

    // Bit positions inside the ctrl register
    localparam int CTRL_SNAP_BIT  = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    // Number of counter types per port
    localparam int NUM_CTR_TYPES = 6;

    // Counter type, as decoded from address[7:4]
    typedef enum logic [3:0] {
        CTR_IN_PKT       = 4'd1,
        CTR_TRANSF_PKT   = 4'd2,
        CTR_IN_FRAME     = 4'd3,
        CTR_TRANSF_FRAME = 4'd4,
        CTR_INV_FRAME    = 4'd5,
        CTR_DROP_FRAME   = 4'd6
    } stats_ctr_e;

    // Zero-based array index of a counter type
    function automatic int ctr_idx(input stats_ctr_e t);
        return int'(t) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stats_counter.sv
// ============================================================================
//  Module  : stats_counter
//  Purpose : Saturating event counter with synchronous clear and a shadow
//            register loaded on snapshot.
//  Ports   : clk, reset (async, active-low)
//            inc    - increment strobe
//            clr    - zero the live value (wins over inc)
//            snap   - copy the pre-update live value into shadow
//            live   - current count
//            shadow - last snapshot
//            step   - high when this cycle's strobe actually advances live
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stats_counter #(
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 snap,
    output logic [CTR_WIDTH-1:0] live,
    output logic [CTR_WIDTH-1:0] shadow,
    output logic                 step
);

    logic w_sat;

    assign w_sat = (live == {CTR_WIDTH{1'b1}});
    assign step  = inc && !clr && !w_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live <= '0;
        end else if (clr) begin
            live <= '0;
        end else if (step) begin
            live <= live + 1'b1;
        end
    end

    // Shadow takes the value before this edge's update, so a strobe or clear
    // in the snapshot cycle is not reflected in the captured copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= live;
        end
    end

endmodule

`default_nettype wire

// File: rtl/port_stats_csr.sv
// ============================================================================
//  Module  : port_stats_csr
//  Purpose : Avalon-MM register slave holding the ingress port mask and six
//            saturating event counters per port, with atomic snapshot, bulk
//            clear and an optional per-port drop-threshold interrupt.
//  Config  : PORT_STATS_IRQ_EN - when defined, irq_status / irq_enable /
//            drop_threshold and the interrupt logic are built; otherwise irq
//            is tied low and addresses 0x02-0x04 read 0 and ignore writes.
//  Ports   : clk, reset (async, active-low)
//            chipselect, read, write, address[7:0], writedata[31:0]
//            readdata[31:0]  - registered, valid one cycle after the read
//            ev_*[NUM_PORTS] - per-port increment strobes
//            port_mask       - ingress enable, active-high
//            irq             - level interrupt
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module port_stats_csr
    import filter_stats_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [7:0]           address,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [NUM_PORTS-1:0] ev_in_pkt,
    input  logic [NUM_PORTS-1:0] ev_transf_pkt,
    input  logic [NUM_PORTS-1:0] ev_in_frame,
    input  logic [NUM_PORTS-1:0] ev_transf_frame,
    input  logic [NUM_PORTS-1:0] ev_inv_frame,
    input  logic [NUM_PORTS-1:0] ev_drop_frame,
    output logic [NUM_PORTS-1:0] port_mask,
    output logic                 irq
);

    localparam int DROP_IDX = ctr_idx(CTR_DROP_FRAME);

    logic                                                    w_wr_en;
    logic                                                    w_rd_en;
    logic                                                    w_snap;
    logic                                                    w_clr;
    logic [NUM_CTR_TYPES-1:0][NUM_PORTS-1:0]                 w_ev;
    logic [NUM_CTR_TYPES-1:0][NUM_PORTS-1:0]                 w_step;
    logic [NUM_CTR_TYPES-1:0][NUM_PORTS-1:0][CTR_WIDTH-1:0]  w_live;
    logic [NUM_CTR_TYPES-1:0][NUM_PORTS-1:0][CTR_WIDTH-1:0]  w_shadow;
    logic [31:0]                                             w_rdata;
    logic [NUM_PORTS-1:0]                                    r_port_mask;

    assign w_wr_en = chipselect && write;
    assign w_rd_en = chipselect && read;
    assign w_snap  = w_wr_en && (address == REG_CTRL) && writedata[CTRL_SNAP_BIT];
    assign w_clr   = w_wr_en && (address == REG_CTRL) && writedata[CTRL_CLEAR_BIT];

    // Array order follows the address map: index t is counter type t+1
    assign w_ev[0] = ev_in_pkt;
    assign w_ev[1] = ev_transf_pkt;
    assign w_ev[2] = ev_in_frame;
    assign w_ev[3] = ev_transf_frame;
    assign w_ev[4] = ev_inv_frame;
    assign w_ev[5] = ev_drop_frame;

    // ------------------------------------------------------------------
    // Counter array
    // ------------------------------------------------------------------
    for (genvar t = 0; t < NUM_CTR_TYPES; t++) begin : g_type
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            stats_counter #(
                .CTR_WIDTH (CTR_WIDTH)
            ) u_ctr (
                .clk    (clk),
                .reset  (reset),
                .inc    (w_ev[t][p]),
                .clr    (w_clr),
                .snap   (w_snap),
                .live   (w_live[t][p]),
                .shadow (w_shadow[t][p]),
                .step   (w_step[t][p])
            );
        end
    end

    // ------------------------------------------------------------------
    // Port mask
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_mask <= '0;
        end else if (w_wr_en && (address == REG_PORT_MASK)) begin
            r_port_mask <= writedata[NUM_PORTS-1:0];
        end
    end

    assign port_mask = r_port_mask;

    // ------------------------------------------------------------------
    // Drop-threshold interrupt
    // ------------------------------------------------------------------
`ifdef PORT_STATS_IRQ_EN
    logic [NUM_PORTS-1:0] r_irq_status;
    logic [NUM_PORTS-1:0] r_irq_enable;
    logic [CTR_WIDTH-1:0] r_drop_thresh;
    logic [NUM_PORTS-1:0] w_irq_set;
    logic [NUM_PORTS-1:0] w_irq_w1c;

    // A port fires when its drop counter steps from thresh-1 to thresh.
    // Comparing against thresh-1 avoids a carry past the counter width.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_irq_set
        assign w_irq_set[p] = w_step[DROP_IDX][p] && (r_drop_thresh != '0) &&
                              (w_live[DROP_IDX][p] == r_drop_thresh - 1'b1);
    end

    assign w_irq_w1c = (w_wr_en && (address == REG_IRQ_STATUS)) ?
                       writedata[NUM_PORTS-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_status  <= '0;
            r_irq_enable  <= '0;
            r_drop_thresh <= '0;
        end else begin
            // Set is applied after the clear so a coincident crossing survives
            r_irq_status <= (r_irq_status & ~w_irq_w1c) | w_irq_set;
            if (w_wr_en && (address == REG_IRQ_ENABLE)) begin
                r_irq_enable <= writedata[NUM_PORTS-1:0];
            end
            if (w_wr_en && (address == REG_DROP_THRESH)) begin
                r_drop_thresh <= writedata[CTR_WIDTH-1:0];
            end
        end
    end

    assign irq = |(r_irq_status & r_irq_enable);
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path: decode from current register state, so a read that
    // coincides with a write to the same register returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (address)
            REG_PORT_MASK:   w_rdata = 32'(r_port_mask);
`ifdef PORT_STATS_IRQ_EN
            REG_IRQ_STATUS:  w_rdata = 32'(r_irq_status);
            REG_IRQ_ENABLE:  w_rdata = 32'(r_irq_enable);
            REG_DROP_THRESH: w_rdata = 32'(r_drop_thresh);
`endif
            default:         w_rdata = '0;
        endcase
        // Counter window; unmatched port indices fall through to 0
        for (int t = 0; t < NUM_CTR_TYPES; t++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ((address[7:4] == 4'(t + 1)) && (address[3:0] == 4'(p))) begin
                    w_rdata = 32'(w_shadow[t][p]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (w_rd_en) begin
            readdata <= w_rdata;
        end
    end

    // Live values of most counters, their step flags and the upper data
    // bits are not consumed in every configuration.
    logic unused_ok;
    assign unused_ok = ^{writedata, w_live, w_step};

endmodule

`default_nettype wire

// File: tb/tb_port_stats_csr.sv
// ============================================================================
//  Module  : tb_port_stats_csr
//  Purpose : Directed self-checking bench for port_stats_csr. Two instances
//            share the bus: dut_a (4 ports, 8-bit counters) and dut_b
//            (2 ports, 32-bit counters). Interrupt expectations follow
//            PORT_STATS_IRQ_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_port_stats_csr;

`ifdef PORT_STATS_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic [3:0]  ev_in_pkt;
    logic [3:0]  ev_transf_pkt;
    logic [3:0]  ev_in_frame;
    logic [3:0]  ev_transf_frame;
    logic [3:0]  ev_inv_frame;
    logic [3:0]  ev_drop_frame;
    logic [3:0]  port_mask_a;
    logic [1:0]  port_mask_b;
    logic        irq_a;
    logic        irq_b;

    int checks;
    int errors;

    port_stats_csr #(.NUM_PORTS(4), .CTR_WIDTH(8)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .chipselect      (chipselect),
        .read            (read),
        .write           (write),
        .address         (address),
        .writedata       (writedata),
        .readdata        (readdata_a),
        .ev_in_pkt       (ev_in_pkt),
        .ev_transf_pkt   (ev_transf_pkt),
        .ev_in_frame     (ev_in_frame),
        .ev_transf_frame (ev_transf_frame),
        .ev_inv_frame    (ev_inv_frame),
        .ev_drop_frame   (ev_drop_frame),
        .port_mask       (port_mask_a),
        .irq             (irq_a)
    );

    port_stats_csr #(.NUM_PORTS(2), .CTR_WIDTH(32)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .chipselect      (chipselect),
        .read            (read),
        .write           (write),
        .address         (address),
        .writedata       (writedata),
        .readdata        (readdata_b),
        .ev_in_pkt       (ev_in_pkt[1:0]),
        .ev_transf_pkt   (ev_transf_pkt[1:0]),
        .ev_in_frame     (ev_in_frame[1:0]),
        .ev_transf_frame (ev_transf_frame[1:0]),
        .ev_inv_frame    (ev_inv_frame[1:0]),
        .ev_drop_frame   (ev_drop_frame[1:0]),
        .port_mask       (port_mask_b),
        .irq             (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] ra,
                            output logic [31:0] rb);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        ra = readdata_a;
        rb = readdata_b;
    endtask

    task automatic set_ev(input int kind, input int port, input logic v);
        case (kind)
            0: ev_in_pkt[port]       = v;
            1: ev_transf_pkt[port]   = v;
            2: ev_in_frame[port]     = v;
            3: ev_transf_frame[port] = v;
            4: ev_inv_frame[port]    = v;
            default: ev_drop_frame[port] = v;
        endcase
    endtask

    // Hold one strobe high for n consecutive rising edges
    task automatic pulse(input int kind, input int port, input int n);
        @(negedge clk);
        set_ev(kind, port, 1'b1);
        repeat (n) @(negedge clk);
        set_ev(kind, port, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] ra, rb;
        checks++;
        if (port_mask_a !== 4'h0 || irq_a !== 1'b0 || readdata_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: mask=%h irq=%b rd=%h required 0/0/0",
                     port_mask_a, irq_a, readdata_a);
        end
        bus_read(8'h00, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL reset_rd_00: got %h required 0", ra); end
        bus_read(8'h12, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL reset_rd_12: got %h required 0", ra); end
        bus_read(8'h02, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL reset_rd_02: got %h required 0", ra); end
    endtask

    task automatic test_basic_count();
        logic [31:0] ra, rb;
        bus_write(8'h00, 32'h0000_000F);
        checks++;
        if (port_mask_a !== 4'hF || port_mask_b !== 2'h3) begin
            errors++;
            $display("FAIL port_mask: a=%h b=%h required F/3", port_mask_a, port_mask_b);
        end
        bus_read(8'h00, ra, rb);
        checks++;
        if (ra !== 32'hF) begin errors++; $display("FAIL rd_mask: got %h required F", ra); end
        pulse(0, 2, 5);
        bus_write(8'h01, 32'h1);
        bus_read(8'h13, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL rd_13: got %h required 0", ra); end
        checks++;
        if (rb !== 32'h0) begin errors++; $display("FAIL b_rd_13: got %h required 0", rb); end
        // Latency: readdata still old while the read is presented, new after
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 8'h12;
        #1;
        checks++;
        if (readdata_a !== 32'h0) begin
            errors++; $display("FAIL rd_latency_early: got %h required 0", readdata_a);
        end
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        checks++;
        if (readdata_a !== 32'd5) begin
            errors++; $display("FAIL rd_12: got %0d required 5", readdata_a);
        end
        checks++;
        if (readdata_b !== 32'd0) begin
            errors++; $display("FAIL b_rd_12: got %0d required 0", readdata_b);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (readdata_a !== 32'd5) begin
            errors++; $display("FAIL rd_hold: got %0d required 5", readdata_a);
        end
        // Counter reads return the shadow, not the live count
        pulse(0, 2, 2);
        bus_read(8'h12, ra, rb);
        checks++;
        if (ra !== 32'd5) begin errors++; $display("FAIL rd_shadow_only: got %0d required 5", ra); end
    endtask

    task automatic test_saturation();
        logic [31:0] ra, rb;
        pulse(5, 0, 300);
        bus_write(8'h01, 32'h1);
        bus_read(8'h60, ra, rb);
        checks++;
        if (ra !== 32'd255) begin errors++; $display("FAIL sat_8bit: got %0d required 255", ra); end
        checks++;
        if (rb !== 32'd300) begin errors++; $display("FAIL b_count_300: got %0d required 300", rb); end
    endtask

    task automatic test_irq();
        logic [31:0] ra, rb;
        bus_write(8'h04, 32'd3);
        bus_read(8'h04, ra, rb);
        checks++;
        if (ra !== (IRQ_ON ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL rd_thresh: got %0d required %0d", ra, IRQ_ON ? 3 : 0);
        end
        bus_write(8'h03, 32'h2);
        @(negedge clk);
        ev_drop_frame[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", irq_a); end
        @(negedge clk);
        ev_drop_frame[1] = 1'b0;
        checks++;
        if (irq_a !== IRQ_ON) begin errors++; $display("FAIL irq_rise: got %b required %b", irq_a, IRQ_ON); end
        bus_read(8'h02, ra, rb);
        checks++;
        if (ra !== (IRQ_ON ? 32'h2 : 32'h0)) begin
            errors++; $display("FAIL rd_status: got %h required %h", ra, IRQ_ON ? 2 : 0);
        end
        bus_write(8'h02, 32'h2);
        checks++;
        if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b required 0", irq_a); end
        // New crossing (3 -> 4) coinciding with a W1C of the same bit
        bus_write(8'h04, 32'd4);
        @(negedge clk);
        ev_drop_frame[1] = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 8'h02; writedata = 32'h2;
        @(negedge clk);
        ev_drop_frame[1] = 1'b0;
        chipselect = 1'b0; write = 1'b0;
        checks++;
        if (irq_a !== IRQ_ON) begin errors++; $display("FAIL irq_set_wins: got %b required %b", irq_a, IRQ_ON); end
        bus_read(8'h02, ra, rb);
        checks++;
        if (ra !== (IRQ_ON ? 32'h2 : 32'h0)) begin
            errors++; $display("FAIL rd_status_set_wins: got %h required %h", ra, IRQ_ON ? 2 : 0);
        end
    endtask

    task automatic test_snap_clear();
        logic [31:0] ra, rb;
        pulse(2, 3, 4);
        @(negedge clk);
        ev_in_frame[3] = 1'b1;
        chipselect = 1'b1; write = 1'b1; address = 8'h01; writedata = 32'h3;
        @(negedge clk);
        ev_in_frame[3] = 1'b0;
        chipselect = 1'b0; write = 1'b0;
        bus_read(8'h33, ra, rb);
        checks++;
        if (ra !== 32'd4) begin errors++; $display("FAIL snap_pre_clear: got %0d required 4", ra); end
        checks++;
        if (rb !== 32'd0) begin errors++; $display("FAIL b_rd_33: got %0d required 0", rb); end
        bus_write(8'h01, 32'h1);
        bus_read(8'h33, ra, rb);
        checks++;
        if (ra !== 32'd0) begin errors++; $display("FAIL live_cleared: got %0d required 0", ra); end
        bus_read(8'h01, ra, rb);
        checks++;
        if (ra !== 32'd0) begin errors++; $display("FAIL rd_ctrl: got %h required 0", ra); end
    endtask

    task automatic test_unmapped();
        logic [31:0] ra, rb;
        bus_write(8'h05, 32'hDEAD_BEEF);
        bus_read(8'h05, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL rd_05: got %h required 0", ra); end
        bus_read(8'h70, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL rd_70: got %h required 0", ra); end
        checks++;
        if (irq_b !== IRQ_ON) begin errors++; $display("FAIL b_irq: got %b required %b", irq_b, IRQ_ON); end
    endtask

    task automatic test_async_reset();
        logic [31:0] ra, rb;
        bus_read(8'h00, ra, rb);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (port_mask_a !== 4'h0 || readdata_a !== 32'h0 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: mask=%h rd=%h irq=%b required 0/0/0",
                     port_mask_a, readdata_a, irq_a);
        end
        @(negedge clk);
        reset = 1'b1;
        bus_read(8'h60, ra, rb);
        checks++;
        if (ra !== 32'h0) begin errors++; $display("FAIL reset_shadow: got %0d required 0", ra); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        ev_in_pkt = '0; ev_transf_pkt = '0; ev_in_frame = '0;
        ev_transf_frame = '0; ev_inv_frame = '0; ev_drop_frame = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_basic_count();
        test_saturation();
        test_irq();
        test_snap_clear();
        test_unmapped();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/port_stats_csr.md
# port_stats_csr

Parametrised successor to the filter's register and statistics logic: an Avalon-MM slave that owns the ingress port enable mask and six saturating per-port event counters across NUM_PORTS ports. It adds atomic snapshotting, bulk clear, and a per-port drop-threshold interrupt. It sits beside the ingress_filter array and counts per-cycle event strobes derived from the AXIS handshakes and filter drop/timeout pulses.

## Interface
- NUM_PORTS, 4: number of ingress ports, 1..16
- CTR_WIDTH, 32: counter width, 8..32; readdata is zero-extended to 32 bits
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- chipselect, read, write  in  1 each  Avalon-MM strobes
- address  in  8  word address
- writedata  in  32  write data
- readdata  out  32  registered read data
- ev_in_pkt, ev_transf_pkt, ev_in_frame, ev_transf_frame, ev_inv_frame, ev_drop_frame  in  NUM_PORTS each  single-cycle increment strobes, bit i = port i
- port_mask  out  NUM_PORTS  ingress enable, active-high
- irq  out  1  level interrupt

## Operation
- Address map:
  - 0x00 port_mask (RW)
  - 0x01 ctrl (W): bit0 snapshot, bit1 clear_all; reads 0
  - 0x02 irq_status (RW1C)
  - 0x03 irq_enable (RW)
  - 0x04 drop_threshold (RW, CTR_WIDTH)
  - 0x10+i..0x60+i: snapshot counters in_pkt, transf_pkt, in_frame, transf_frame, inv_frame, drop_frame
  - Counter type is address[7:4] = 1..6; port is address[3:0].
  - Port index ≥ NUM_PORTS and unmapped addresses read 0; writes to them are ignored.
- Live counters: each increments by 1 on its strobe and saturates at 2^CTR_WIDTH−1 (no wrap).
- Snapshot: a write of ctrl bit0 copies all 6×NUM_PORTS live counters into shadow registers in one cycle. Counter reads always return the shadow copy. A strobe in the snapshot cycle is not included in the snapshot; it lands in the live counter.
- clear_all: zeroes all live counters; a strobe in the same cycle is lost (clear wins). Shadows are unaffected. When bit0 and bit1 are written together, the snapshot captures the pre-clear values.
- Drop interrupt: irq_status[i] sets when live drop_frame[i] increments to a value equal to drop_threshold. A threshold of 0 never fires. Set has priority over a W1C in the same cycle.
- irq = |(irq_status & irq_enable).

## Timing
- Reset values (asynchronous): readdata 0, port_mask 0, irq 0, irq_status/irq_enable 0, drop_threshold 0, all counters and shadows 0.
- Read latency 1 cycle: readdata is valid the cycle after chipselect&read and holds its value until the next read. No wait states.
- Writes take effect at the clock edge of chipselect&write; port_mask changes the following cycle.
- A counter strobe at edge N is visible in a snapshot taken at edge N+1 or later.
- irq asserts one cycle after the threshold-crossing strobe, or one cycle after the enable write.
- A simultaneous read and write to the same register returns the old value.
- Reset asserted mid-operation clears everything immediately and asynchronously. Deassertion is synchronised externally.

## Configuration
- PORT_STATS_IRQ_EN defined: drop-threshold interrupt logic, irq_status, irq_enable and drop_threshold are present as described.
- PORT_STATS_IRQ_EN undefined: that logic is compiled out, irq is tied 0, and addresses 0x02–0x04 read 0 and ignore writes.

## Structure
- Package filter_stats_pkg holds:
  - register address constants (REG_PORT_MASK, REG_CTRL, REG_IRQ_STATUS, REG_IRQ_ENABLE, REG_DROP_THRESH)
  - counter-type enum stats_ctr_e (CTR_IN_PKT..CTR_DROP_FRAME = 1..6)
  - ctrl bit positions
- Sub-module stats_counter: parametrised CTR_WIDTH saturating counter with inc, clr, snap inputs and live/shadow outputs. It is instantiated 6×NUM_PORTS times via generate.

## Test plan
- Reset, then read 0x00, 0x12, 0x02 → each returns 0; irq=0.
- Write 0x00=0xF, pulse ev_in_pkt[2] 5 times, write ctrl=1, read 0x12 → 5; read 0x13 → 0; readdata appears exactly 1 cycle after read.
- CTR_WIDTH=8: pulse ev_drop_frame[0] 300 times, snapshot, read 0x60 → 255 (saturated, no wrap).
- drop_threshold=3, irq_enable=0x2, pulse ev_drop_frame[1] 3 times → irq rises 1 cycle after the third strobe. Write 0x02=0x2 → irq falls. A W1C coinciding with a new crossing leaves the status bit set.
- Pulse ev_in_frame[3] in the same cycle as ctrl=0x3 → snapshot holds the pre-clear count, live counter is 0, and that cycle's strobe is lost.
- NUM_PORTS=2: read 0x13 → 0. Build without PORT_STATS_IRQ_EN → 0x04 reads 0 after a write, and irq stays 0.
